sdram_init_monitor: RTL and testbench
=====================================

# sdram_init_monitor

Passive responder-side checker for the SDRAM power-up protocol. Sits on the SDRAM command bus in parallel with the device and decodes every sampled command. Verifies the JEDEC-style initialization sequence: power-up NOPs, precharge-all, auto-refresh burst, mode-register load, tMRD wait. Reports completion, a sticky error code, the refresh count and the captured mode word, for use as an on-chip self-check and as a bench scoreboard.

## Interface

- POWERUP_CYCLES, 10000: minimum sampled NOP/DESELECT cycles before the first precharge-all
- TRP_CYCLES, 1: minimum gap, PALL to first REF
- TRFC_CYCLES, 2: minimum gap, REF to next REF or MRS
- TMRD_CYCLES, 2: NOP cycles after MRS before done
- MIN_REFRESH, 8: minimum REF count before MRS
- EXP_MODE, 13'h0023: required MRS address (burst 8, sequential, CL2)

- iclk  in  1  clock; bus sampled on rising edge
- ctr_reset  in  1  reset, asynchronous, active-high
- ienb  in  1  bus-valid qualifier; bus is high-Z when low
- cke  in  1  DRAM_CKE
- cs_n, ras_n, cas_n, we_n  in  1 each  command pins
- addr  in  13  DRAM_ADDR
- ba  in  2  DRAM_BA
- odone  out  1  legal sequence complete
- oerr  out  1  sticky error flag
- oerr_code  out  3  first error detected
- orefcnt  out  8  REF commands accepted, saturating at 255
- omode  out  13  addr captured at MRS

## Operation

- Reset values: odone=0, oerr=0, oerr_code=0, orefcnt=0, omode=0, state=WAIT_PWR, all counters 0.
- Cycles with ienb=0 are ignored; counters and state hold.
- Decode of {cs_n,ras_n,cas_n,we_n}: 1xxx DESELECT, treated as NOP. 0111 NOP. 0010 PRE. 0001 REF. 0000 MRS. All others (ACT, READ, WRITE, BST) are ILLEGAL.
- PRE with addr[10]=0 is a single-bank precharge.
- Gap counter (16 bit, saturating):
  - Loaded with 1 on every non-NOP command.
  - Incremented on every sampled NOP.
  - When a command arrives, the current counter value is its gap from the previous command.
- Error codes:
  - 0 NONE
  - 1 EARLY: command before the power-up count
  - 2 TIMING: gap below its minimum
  - 3 FEWREF: MRS with orefcnt < MIN_REFRESH
  - 4 MODE: addr≠EXP_MODE or ba≠0 at MRS
  - 5 ILLEGAL: illegal command, or cke=0 while ienb=1 before DONE
  - 6 BANK: single-bank precharge
- Any error moves the FSM to ERROR and latches oerr=1 and the code. ERROR is left only by reset.
- If several errors apply on one cycle, the lowest code wins.
- FSM states:
  - WAIT_PWR: count NOPs (16-bit, saturating). PALL with count ≥ POWERUP_CYCLES goes to WAIT_REF. PALL earlier, or any REF/MRS, is EARLY.
  - WAIT_REF: REF with gap ≥ TRP_CYCLES goes to REFRESHING with orefcnt=1. REF with a shorter gap is TIMING. MRS is FEWREF. PRE is ILLEGAL.
  - REFRESHING:
    - REF with gap ≥ TRFC_CYCLES increments orefcnt.
    - MRS with gap ≥ TRFC_CYCLES goes to LOADED and captures omode=addr, after the FEWREF and MODE checks.
    - A short gap is TIMING. PRE is ILLEGAL.
  - LOADED: when gap reaches TMRD_CYCLES with only NOPs sampled, go to DONE. Any command before that is TIMING.
  - DONE: odone=1. Checking stops; all bus activity is ignored.
  - ERROR: odone=0.

## Timing

- All outputs are registered.
- odone, oerr and orefcnt update on the edge that samples the triggering command or NOP, so they are visible one cycle after the bus value.
- The MRS that completes the sequence, followed by TMRD_CYCLES NOPs, gives odone high TMRD_CYCLES cycles after the MRS sample edge.
- Asynchronous reset mid-sequence returns the block to WAIT_PWR immediately. The sequence must then restart from power-up NOPs.
- The power-up count saturates at 0xFFFF, so arbitrarily long NOP periods are legal.

## Structure

- Shared package sdram_pkg holds:
  - command encodings CMD_NOP 4'b0111, CMD_MRS 4'b0000, CMD_REF 4'b0001, CMD_PALL 4'b0010
  - the cmd_t enum {DESEL, NOP, PRE, REF, MRS, ILLEGAL}
  - the err_t error-code enum
  - the monitor state enum
- One combinational sub-module, sdram_cmd_decode. Inputs: cs_n, ras_n, cas_n, we_n, addr[10]. Outputs: cmd_t and an is_pall flag.
- FSM, gap counter, power-up counter and output registers live in the top module.

## Test plan

All scenarios use POWERUP_CYCLES=20.

- Legal sequence: 25 NOPs, PALL (A10=1), 8× REF/NOP pairs, MRS 13'h0023, NOPs -> odone=1 two cycles after MRS, orefcnt=8, omode=13'h0023, oerr=0.
- Early precharge: PALL after 10 NOPs -> oerr=1, oerr_code=1, odone stays 0.
- Back-to-back REFs (gap 1) in REFRESHING -> oerr_code=2.
- Too few refreshes: MRS after 5 REFs -> oerr_code=3, omode stays 0.
- Mode mismatch: MRS addr 13'h0033 -> oerr_code=4.
- Disruptions:
  - ACT (0011) mid-refresh -> oerr_code=5.
  - ienb=0 for 50 cycles mid-sequence -> no state change.
  - ctr_reset pulse after 4 REFs -> all outputs 0, and a full legal replay then reaches odone=1.

Source files
------------

// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg: SDRAM command encodings and monitor types.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_PALL = 4'b0010;

  typedef enum logic [2:0] {
    DESEL   = 3'd0,
    NOP     = 3'd1,
    PRE     = 3'd2,
    REF     = 3'd3,
    MRS     = 3'd4,
    ILLEGAL = 3'd5
  } cmd_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_EARLY   = 3'd1,
    ERR_TIMING  = 3'd2,
    ERR_FEWREF  = 3'd3,
    ERR_MODE    = 3'd4,
    ERR_ILLEGAL = 3'd5,
    ERR_BANK    = 3'd6
  } err_t;

  typedef enum logic [2:0] {
    ST_WAIT_PWR   = 3'd0,
    ST_WAIT_REF   = 3'd1,
    ST_REFRESHING = 3'd2,
    ST_LOADED     = 3'd3,
    ST_DONE       = 3'd4,
    ST_ERROR      = 3'd5
  } mon_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_cmd_decode.sv
// ---------------------------------------------------------------------------
// sdram_cmd_decode: combinational decode of the SDRAM command pins.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sdram_cmd_decode
  import sdram_pkg::*;
(
  input  logic cs_n,
  input  logic ras_n,
  input  logic cas_n,
  input  logic we_n,
  input  logic a10,
  output cmd_t cmd,
  output logic is_pall
);

  logic [3:0] pins;

  assign pins = {cs_n, ras_n, cas_n, we_n};

  always_comb begin
    cmd     = ILLEGAL;
    is_pall = 1'b0;
    if (cs_n) begin
      cmd = DESEL;
    end else if (pins == CMD_NOP) begin
      cmd = NOP;
    end else if (pins == CMD_PALL) begin
      // A10 distinguishes precharge-all from a single-bank precharge
      cmd     = PRE;
      is_pall = a10;
    end else if (pins == CMD_REF) begin
      cmd = REF;
    end else if (pins == CMD_MRS) begin
      cmd = MRS;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sdram_init_monitor.sv
// ---------------------------------------------------------------------------
// sdram_init_monitor: passive checker for the SDRAM power-up sequence.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sdram_init_monitor
  import sdram_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 10000,
  parameter int unsigned TRP_CYCLES     = 1,
  parameter int unsigned TRFC_CYCLES    = 2,
  parameter int unsigned TMRD_CYCLES    = 2,
  parameter int unsigned MIN_REFRESH    = 8,
  parameter logic [12:0] EXP_MODE       = 13'h0023
) (
  input  logic        iclk,
  input  logic        ctr_reset,
  input  logic        ienb,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [12:0] addr,
  input  logic [1:0]  ba,
  output logic        odone,
  output logic        oerr,
  output logic [2:0]  oerr_code,
  output logic [7:0]  orefcnt,
  output logic [12:0] omode
);

  localparam logic [15:0] PWR_MIN  = 16'(POWERUP_CYCLES);
  localparam logic [15:0] TRP_MIN  = 16'(TRP_CYCLES);
  localparam logic [15:0] TRFC_MIN = 16'(TRFC_CYCLES);
  localparam logic [15:0] TMRD_MIN = 16'(TMRD_CYCLES);
  localparam logic [7:0]  REF_MIN  = 8'(MIN_REFRESH);

  cmd_t       cmd;
  logic       is_pall;
  logic       nop_like;
  logic       checking;
  mon_state_t state;
  mon_state_t state_nxt;
  logic [15:0] gap_cnt;
  logic [15:0] pwr_cnt;
  logic [7:0]  refcnt_nxt;
  logic [12:0] mode_nxt;
  logic e_early, e_timing, e_fewref, e_mode, e_illegal, e_bank;
  logic err_any;
  err_t err_sel;

  sdram_cmd_decode u_decode (
    .cs_n    (cs_n),
    .ras_n   (ras_n),
    .cas_n   (cas_n),
    .we_n    (we_n),
    .a10     (addr[10]),
    .cmd     (cmd),
    .is_pall (is_pall)
  );

  assign nop_like = (cmd == DESEL) || (cmd == NOP);
  assign checking = ienb && (state != ST_DONE) && (state != ST_ERROR);

  always_comb begin
    e_early    = 1'b0;
    e_timing   = 1'b0;
    e_fewref   = 1'b0;
    e_mode     = 1'b0;
    e_illegal  = 1'b0;
    e_bank     = 1'b0;
    state_nxt  = state;
    refcnt_nxt = orefcnt;
    mode_nxt   = omode;
    if (checking) begin
      if (!cke || cmd == ILLEGAL) e_illegal = 1'b1;
      case (state)
        ST_WAIT_PWR: begin
          if (cmd == REF || cmd == MRS) e_early = 1'b1;
          if (cmd == PRE) begin
            if (!is_pall)               e_bank    = 1'b1;
            else if (pwr_cnt < PWR_MIN) e_early   = 1'b1;
            else                        state_nxt = ST_WAIT_REF;
          end
        end
        ST_WAIT_REF: begin
          if (cmd == REF) begin
            if (gap_cnt < TRP_MIN) begin
              e_timing = 1'b1;
            end else begin
              state_nxt  = ST_REFRESHING;
              refcnt_nxt = 8'd1;
            end
          end
          if (cmd == MRS) e_fewref  = 1'b1;
          if (cmd == PRE) e_illegal = 1'b1;
        end
        ST_REFRESHING: begin
          if (cmd == REF) begin
            if (gap_cnt < TRFC_MIN)      e_timing   = 1'b1;
            else if (orefcnt != 8'hFF)   refcnt_nxt = orefcnt + 8'd1;
          end
          // Any error flagged here blocks the state change and the mode capture
          if (cmd == MRS) begin
            if (gap_cnt < TRFC_MIN)                e_timing = 1'b1;
            if (orefcnt < REF_MIN)                 e_fewref = 1'b1;
            if (addr != EXP_MODE || ba != 2'b00)   e_mode   = 1'b1;
            state_nxt = ST_LOADED;
            mode_nxt  = addr;
          end
          if (cmd == PRE) e_illegal = 1'b1;
        end
        ST_LOADED: begin
          if (!nop_like)                 e_timing  = 1'b1;
          else if (gap_cnt >= TMRD_MIN)  state_nxt = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  assign err_any = e_early | e_timing | e_fewref | e_mode | e_illegal | e_bank;

  // Lowest code wins when several errors coincide
  always_comb begin
    err_sel = ERR_NONE;
    if (e_early)        err_sel = ERR_EARLY;
    else if (e_timing)  err_sel = ERR_TIMING;
    else if (e_fewref)  err_sel = ERR_FEWREF;
    else if (e_mode)    err_sel = ERR_MODE;
    else if (e_illegal) err_sel = ERR_ILLEGAL;
    else if (e_bank)    err_sel = ERR_BANK;
  end

  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      state     <= ST_WAIT_PWR;
      gap_cnt   <= 16'd0;
      pwr_cnt   <= 16'd0;
      odone     <= 1'b0;
      oerr      <= 1'b0;
      oerr_code <= 3'd0;
      orefcnt   <= 8'd0;
      omode     <= 13'd0;
    end else if (checking) begin
      gap_cnt <= nop_like ? sat_inc16(gap_cnt) : 16'd1;
      if (state == ST_WAIT_PWR && nop_like) pwr_cnt <= sat_inc16(pwr_cnt);
      if (err_any) begin
        state     <= ST_ERROR;
        oerr      <= 1'b1;
        oerr_code <= err_sel;
        odone     <= 1'b0;
      end else begin
        state   <= state_nxt;
        orefcnt <= refcnt_nxt;
        omode   <= mode_nxt;
        odone   <= (state_nxt == ST_DONE);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sdram_init_monitor.sv
// ---------------------------------------------------------------------------
// tb_sdram_init_monitor: scenario and randomized bench with a reference model.
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_sdram_init_monitor;

  localparam int PWR  = 20;
  localparam int TRP  = 1;
  localparam int TRFC = 2;
  localparam int TMRD = 2;
  localparam int MINR = 8;

  localparam logic [3:0] P_NOP  = 4'b0111;
  localparam logic [3:0] P_PRE  = 4'b0010;
  localparam logic [3:0] P_REF  = 4'b0001;
  localparam logic [3:0] P_MRS  = 4'b0000;
  localparam logic [3:0] P_ACT  = 4'b0011;

  logic        iclk = 1'b0;
  logic        ctr_reset;
  logic        ienb, cke, cs_n, ras_n, cas_n, we_n;
  logic [12:0] addr;
  logic [1:0]  ba;
  logic        odone, oerr;
  logic [2:0]  oerr_code;
  logic [7:0]  orefcnt;
  logic [12:0] omode;
  logic [25:0] dut_vec;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  c;
    logic [12:0] a;
    logic [1:0]  b;
  } op_t;

  sdram_init_monitor #(
    .POWERUP_CYCLES (PWR),
    .TRP_CYCLES     (TRP),
    .TRFC_CYCLES    (TRFC),
    .TMRD_CYCLES    (TMRD),
    .MIN_REFRESH    (MINR),
    .EXP_MODE       (13'h0023)
  ) dut (
    .iclk      (iclk),
    .ctr_reset (ctr_reset),
    .ienb      (ienb),
    .cke       (cke),
    .cs_n      (cs_n),
    .ras_n     (ras_n),
    .cas_n     (cas_n),
    .we_n      (we_n),
    .addr      (addr),
    .ba        (ba),
    .odone     (odone),
    .oerr      (oerr),
    .oerr_code (oerr_code),
    .orefcnt   (orefcnt),
    .omode     (omode)
  );

  always #5 iclk = ~iclk;

  assign dut_vec = {odone, oerr, oerr_code, orefcnt, omode};

  // Reference model: timestamps of sampled cycles instead of counters
  int          m_t, m_last, m_nref;
  bit          m_pall, m_loaded, m_done, m_err;
  logic [2:0]  m_code;
  logic [12:0] m_mode;

  function automatic void model_reset();
    m_t = 0; m_last = 0; m_nref = 0;
    m_pall = 0; m_loaded = 0; m_done = 0; m_err = 0;
    m_code = 3'd0; m_mode = 13'd0;
  endfunction

  function automatic int lo(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  function automatic void model_step(input logic [3:0] c, input logic [12:0] a,
                                     input logic [1:0] b, input logic ck);
    int gap, best;
    bit nop;
    if (m_done || m_err) return;
    nop  = c[3] || (c == P_NOP);
    gap  = lo(m_t - m_last, 65535);
    best = 7;
    if (!ck) best = 5;
    if (!nop && c != P_PRE && c != P_REF && c != P_MRS) best = lo(best, 5);
    if (m_loaded) begin
      if (!nop) best = lo(best, 2);
    end else if (!m_pall) begin
      if (c == P_REF || c == P_MRS) best = lo(best, 1);
      if (c == P_PRE) best = lo(best, !a[10] ? 6 : (m_t < PWR ? 1 : 7));
    end else if (m_nref == 0) begin
      if (c == P_REF && gap < TRP) best = lo(best, 2);
      if (c == P_MRS) best = lo(best, 3);
      if (c == P_PRE) best = lo(best, 5);
    end else begin
      if (c == P_REF && gap < TRFC) best = lo(best, 2);
      if (c == P_MRS) begin
        if (gap < TRFC) best = lo(best, 2);
        if (m_nref < MINR) best = lo(best, 3);
        if (a != 13'h0023 || b != 2'b00) best = lo(best, 4);
      end
      if (c == P_PRE) best = lo(best, 5);
    end
    if (best < 7) begin
      m_err  = 1;
      m_code = 3'(best);
    end else begin
      if (m_loaded && nop && gap >= TMRD) m_done = 1;
      if (c == P_PRE) m_pall = 1;
      if (c == P_REF) m_nref = lo(m_nref + 1, 255);
      if (c == P_MRS) begin m_loaded = 1; m_mode = a; end
    end
    if (!nop) m_last = m_t;
    m_t++;
  endfunction

  function automatic logic [25:0] mvec();
    return {m_done, m_err, m_code, 8'(m_nref), m_mode};
  endfunction

  task automatic bus(input logic [3:0] c, input logic [12:0] a, input logic [1:0] b,
                     input logic en, input logic ck);
    @(negedge iclk);
    {cs_n, ras_n, cas_n, we_n} = c;
    addr = a; ba = b; ienb = en; cke = ck;
    @(posedge iclk);
    if (en) model_step(c, a, b, ck);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [12:0] a);
    bus(c, a, 2'b00, 1'b1, 1'b1);
  endtask

  task automatic nops(input int n);
    logic [3:0] c;
    for (int i = 0; i < n; i++) begin
      c = ($urandom_range(0, 1) == 0) ? P_NOP : {1'b1, 3'($urandom)};
      bus(c, 13'($urandom), 2'($urandom), 1'b1, 1'b1);
    end
  endtask

  task automatic reset_dut();
    @(negedge iclk);
    #2;
    ctr_reset = 1'b1; ienb = 1'b0; cke = 1'b1;
    {cs_n, ras_n, cas_n, we_n} = P_NOP;
    @(negedge iclk);
    #2;
    ctr_reset = 1'b0;
    model_reset();
  endtask

  task automatic legal_prefix(input int nref);
    nops(25);
    issue(P_PRE, 13'h0400 | 13'($urandom));
    for (int i = 0; i < nref; i++) begin
      issue(P_REF, 13'($urandom));
      nops(1);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (dut_vec !== 26'd0) begin
      errors++; $display("FAIL reset_state outputs=%h exp=0", dut_vec);
    end
  endtask

  task automatic test_legal();
    logic [25:0] held;
    reset_dut();
    legal_prefix(8);
    issue(P_MRS, 13'h0023);
    checks++;
    if (odone !== 1'b0) begin errors++; $display("FAIL legal_mrs_edge odone=%0b exp=0", odone); end
    nops(1);
    checks++;
    if (odone !== 1'b0) begin errors++; $display("FAIL legal_tmrd1 odone=%0b exp=0", odone); end
    nops(1);
    checks++;
    if ({odone, oerr, oerr_code, orefcnt, omode} !== {1'b1, 1'b0, 3'd0, 8'd8, 13'h0023}) begin
      errors++; $display("FAIL legal_done outputs=%h exp=%h", dut_vec, {1'b1, 1'b0, 3'd0, 8'd8, 13'h0023});
    end
    held = dut_vec;
    for (int i = 0; i < 8; i++) bus(4'($urandom), 13'($urandom), 2'($urandom), 1'b1, 1'($urandom));
    checks++;
    if (dut_vec !== held) begin errors++; $display("FAIL done_ignores_bus outputs=%h exp=%h", dut_vec, held); end
  endtask

  task automatic test_early();
    reset_dut();
    nops(10);
    issue(P_PRE, 13'h0400);
    checks++;
    if ({odone, oerr, oerr_code} !== {1'b0, 1'b1, 3'd1}) begin
      errors++; $display("FAIL early_pall done/err/code=%b exp=0_1_001", {odone, oerr, oerr_code});
    end
    reset_dut();
    nops(PWR - 1);
    issue(P_PRE, 13'h0400);
    checks++;
    if (oerr_code !== 3'd1) begin errors++; $display("FAIL early_boundary code=%0d exp=1", oerr_code); end
    reset_dut();
    nops(PWR);
    issue(P_PRE, 13'h0400);
    checks++;
    if (oerr !== 1'b0) begin errors++; $display("FAIL pall_at_boundary oerr=%0b exp=0", oerr); end
    reset_dut();
    nops(PWR);
    issue(P_PRE, 13'h0000);
    checks++;
    if (oerr_code !== 3'd6) begin errors++; $display("FAIL single_bank code=%0d exp=6", oerr_code); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    legal_prefix(2);
    issue(P_REF, 13'd0);
    issue(P_REF, 13'd0);
    checks++;
    if ({oerr, oerr_code} !== {1'b1, 3'd2}) begin
      errors++; $display("FAIL back_to_back err/code=%b exp=1_010", {oerr, oerr_code});
    end
    checks++;
    if (dut_vec !== mvec()) begin errors++; $display("FAIL b2b_model outputs=%h exp=%h", dut_vec, mvec()); end
  endtask

  task automatic test_fewref();
    reset_dut();
    legal_prefix(5);
    issue(P_MRS, 13'h0023);
    checks++;
    if ({oerr_code, omode} !== {3'd3, 13'd0}) begin
      errors++; $display("FAIL fewref code=%0d mode=%h exp=3/0000", oerr_code, omode);
    end
  endtask

  task automatic test_mode();
    reset_dut();
    legal_prefix(8);
    issue(P_MRS, 13'h0033);
    checks++;
    if ({oerr_code, odone} !== {3'd4, 1'b0}) begin
      errors++; $display("FAIL mode_mismatch code=%0d done=%0b exp=4/0", oerr_code, odone);
    end
    reset_dut();
    legal_prefix(8);
    bus(P_MRS, 13'h0023, 2'b01, 1'b1, 1'b1);
    checks++;
    if (oerr_code !== 3'd4) begin errors++; $display("FAIL mode_bank code=%0d exp=4", oerr_code); end
  endtask

  task automatic test_illegal();
    reset_dut();
    legal_prefix(3);
    issue(P_ACT, 13'd0);
    checks++;
    if (oerr_code !== 3'd5) begin errors++; $display("FAIL act_mid_refresh code=%0d exp=5", oerr_code); end
    reset_dut();
    legal_prefix(3);
    bus(P_NOP, 13'd0, 2'b00, 1'b1, 1'b0);
    checks++;
    if (oerr_code !== 3'd5) begin errors++; $display("FAIL cke_low code=%0d exp=5", oerr_code); end
  endtask

  task automatic test_ienb_hold();
    logic [25:0] held;
    reset_dut();
    legal_prefix(3);
    held = dut_vec;
    for (int i = 0; i < 50; i++) bus(4'($urandom), 13'($urandom), 2'($urandom), 1'b0, 1'($urandom));
    checks++;
    if (dut_vec !== held) begin errors++; $display("FAIL ienb_hold outputs=%h exp=%h", dut_vec, held); end
    for (int i = 0; i < 5; i++) begin
      issue(P_REF, 13'd0);
      nops(1);
    end
    issue(P_MRS, 13'h0023);
    nops(2);
    checks++;
    if ({odone, oerr, orefcnt} !== {1'b1, 1'b0, 8'd8}) begin
      errors++; $display("FAIL ienb_resume done/err/ref=%h exp=%h", {odone, oerr, orefcnt}, {1'b1, 1'b0, 8'd8});
    end
  endtask

  task automatic test_reset_replay();
    reset_dut();
    legal_prefix(4);
    @(negedge iclk);
    #2;
    ctr_reset = 1'b1; ienb = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 26'd0) begin errors++; $display("FAIL async_reset outputs=%h exp=0", dut_vec); end
    @(negedge iclk);
    #2;
    ctr_reset = 1'b0;
    model_reset();
    legal_prefix(8);
    issue(P_MRS, 13'h0023);
    nops(2);
    checks++;
    if ({odone, oerr, orefcnt, omode} !== {1'b1, 1'b0, 8'd8, 13'h0023}) begin
      errors++; $display("FAIL replay_done outputs=%h exp=%h", dut_vec, mvec());
    end
  endtask

  task automatic test_refsat();
    reset_dut();
    legal_prefix(260);
    checks++;
    if (orefcnt !== 8'd255) begin errors++; $display("FAIL refcnt_saturate ref=%0d exp=255", orefcnt); end
    issue(P_MRS, 13'h0023);
    nops(2);
    checks++;
    if ({odone, orefcnt} !== {1'b1, 8'd255}) begin
      errors++; $display("FAIL refsat_done done=%0b ref=%0d exp=1/255", odone, orefcnt);
    end
  endtask

  task automatic test_random();
    op_t plan[$];
    op_t op;
    logic [3:0] c;
    logic en, ck;
    int r, g;
    for (int tr = 0; tr < 16; tr++) begin
      reset_dut();
      plan.delete();
      for (int i = 0; i < int'($urandom_range(17, 24)); i++)
        plan.push_back('{P_NOP, 13'($urandom), 2'b00});
      plan.push_back('{P_PRE, ($urandom_range(0, 9) == 0) ? 13'h0000 : 13'h0400, 2'b00});
      for (int k = 0; k < int'($urandom_range(5, 10)); k++) begin
        g = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 2));
        for (int i = 0; i < g; i++) plan.push_back('{P_NOP, 13'd0, 2'b00});
        plan.push_back('{P_REF, 13'($urandom), 2'b00});
      end
      plan.push_back('{P_NOP, 13'd0, 2'b00});
      plan.push_back('{P_MRS, ($urandom_range(0, 4) == 0) ? 13'($urandom) : 13'h0023,
                       ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00});
      for (int i = 0; i < 4; i++) plan.push_back('{P_NOP, 13'd0, 2'b00});
      foreach (plan[i]) begin
        op = plan[i];
        c = op.c; en = 1'b1; ck = 1'b1;
        r = int'($urandom_range(0, 99));
        if (r < 3)      en = 1'b0;
        else if (r < 5) ck = 1'b0;
        else if (r < 7) c  = 4'($urandom);
        bus(c, op.a, op.b, en, ck);
        checks++;
        if (dut_vec !== mvec()) begin
          errors++;
          $display("FAIL random_t%0d_c%0d outputs=%h exp=%h", tr, i, dut_vec, mvec());
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    ctr_reset = 1'b1; ienb = 1'b0; cke = 1'b1;
    {cs_n, ras_n, cas_n, we_n} = P_NOP;
    addr = 13'd0; ba = 2'b00;
    model_reset();
    repeat (3) @(posedge iclk);
    test_reset();
    test_legal();
    test_early();
    test_back_to_back();
    test_fewref();
    test_mode();
    test_illegal();
    test_ienb_hold();
    test_reset_replay();
    test_refsat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
